// File: rtl/spectrum_to_ram.sv
// spectrum_to_ram: scales each spectrum bin to a bar height and writes it into every column of that bar.
module spectrum_to_ram #(
  parameter int XSTART         = 0,
  parameter int BARWIDTH       = 12,
  parameter int BANK_COLS      = 144,
  parameter int DATAW          = 16,
  parameter int HEIGHTW        = 10,
  parameter int SHIFT          = 6,
  parameter int MAXHEIGHT      = 479,
  parameter int RAM_ADDR_WIDTH = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATAW-1:0]          s_mag,
  input  logic                      s_last,
  output logic [3:0]                wr_bank,
  output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [HEIGHTW-1:0]        wr_data,
  output logic                      frame_done,
  output logic                      busy
);
  localparam int NUM_BARS = 4 * BANK_COLS / BARWIDTH;
  localparam int BW = $clog2(NUM_BARS);
  localparam int CW = $clog2(BARWIDTH);
  localparam int AW = RAM_ADDR_WIDTH;

  if ((BANK_COLS % BARWIDTH) != 0 || XSTART < 0) begin : g_bad_param
    $error("BARWIDTH must divide BANK_COLS and XSTART must be non-negative");
  end

  typedef enum logic [2:0] {ACCEPT, WRITE, FLUSH, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       bar_q, bar_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          bank_q, bank_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [HEIGHTW-1:0]  height_q, height_d;
  logic                last_q, last_d;
  logic [3:0]          wr_bank_q, wr_bank_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [HEIGHTW-1:0]  wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                emit;
  logic [HEIGHTW-1:0]  emit_data;
  logic [DATAW-1:0]    mag_sh;
  logic [HEIGHTW-1:0]  mag_h;
  logic                bank_end;

  assign mag_sh     = s_mag >> SHIFT;
  assign mag_h      = (mag_sh > DATAW'(MAXHEIGHT)) ? HEIGHTW'(MAXHEIGHT) : mag_sh[HEIGHTW-1:0];
  assign bank_end   = addr_q == AW'(BANK_COLS - 1);
  assign s_ready    = state_q == ACCEPT || state_q == DRAIN;
  assign busy       = state_q != ACCEPT;
  assign wr_bank    = wr_bank_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d   = state_q;
    bar_d     = bar_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    height_d  = height_q;
    last_d    = last_q;
    wr_bank_d = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    emit      = 1'b0;
    emit_data = '0;
    case (state_q)
      ACCEPT: if (s_valid) begin
        height_d  = mag_h;
        last_d    = s_last;
        state_d   = WRITE;
        emit      = 1'b1;
        emit_data = mag_h;
      end
      WRITE: if (cnt_q != CW'(BARWIDTH - 1)) begin
        cnt_d     = cnt_q + 1'b1;
        emit      = 1'b1;
        emit_data = height_q;
      end else begin
        cnt_d = '0;
        if (bar_q == BW'(NUM_BARS - 1)) state_d = last_q ? DONE : DRAIN;
        else if (last_q) begin
          state_d = FLUSH;
          emit    = 1'b1;
        end else begin
          bar_d   = bar_q + 1'b1;
          state_d = ACCEPT;
        end
      end
      FLUSH: if (wr_bank_q[0] && wr_addr_q == AW'(BANK_COLS - 1)) state_d = DONE;
             else emit = 1'b1;
      DRAIN: if (s_valid && s_last) state_d = DONE;
      default: begin
        state_d = ACCEPT;
        bar_d   = '0;
        cnt_d   = '0;
        bank_d  = 4'b1000;
        addr_d  = '0;
      end
    endcase
    // the column pointer walks banks by shifting the one-hot select at each bank boundary
    if (emit) begin
      wr_bank_d = bank_q;
      wr_addr_d = addr_q;
      wr_data_d = emit_data;
      bank_d    = bank_end ? bank_q >> 1 : bank_q;
      addr_d    = bank_end ? '0 : addr_q + 1'b1;
    end
    frame_done_d = state_d == DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ACCEPT;
      bar_q        <= '0;
      cnt_q        <= '0;
      bank_q       <= 4'b1000;
      addr_q       <= '0;
      height_q     <= '0;
      last_q       <= 1'b0;
      wr_bank_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bar_q        <= bar_d;
      cnt_q        <= cnt_d;
      bank_q       <= bank_d;
      addr_q       <= addr_d;
      height_q     <= height_d;
      last_q       <= last_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_spectrum_to_ram.sv
// tb_spectrum_to_ram: directed scenario tests for the bar write engine.
module tb_spectrum_to_ram;
  logic        clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [15:0] s_mag = '0;
  logic        s_ready, frame_done, busy;
  logic [3:0]  wr_bank;
  logic [10:0] wr_addr;
  logic [9:0]  wr_data;

  spectrum_to_ram dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_mag(s_mag),
    .s_last(s_last), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] b; logic [10:0] a; logic [9:0] d;} wr_t;
  wr_t wq[$];
  int  wcyc[$];
  int  cyc = 0, fd_cnt = 0, fd_cyc = 0, acc_cnt = 0, acc_first = 0, acc_last = 0, rdy_bad = 0;
  int  checks = 0, errors = 0, last_wait = 0;
  int  bar_h[48];

  always @(posedge clk) cyc <= cyc + 1;

  // log every write, frame_done and handshake away from the active edge
  always @(negedge clk) begin
    if (wr_bank != 4'b0) begin
      wq.push_back({wr_bank, wr_addr, wr_data});
      wcyc.push_back(cyc);
      if (s_ready) rdy_bad++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (rst_n && s_valid && s_ready) begin
      if (acc_cnt == 0) acc_first = cyc + 1;
      acc_last = cyc + 1;
      acc_cnt++;
    end
  end

  task step;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    step;
    step;
    rst_n = 1'b1;
  endtask

  task clear_log;
    wq.delete();
    wcyc.delete();
    fd_cnt = 0;
    acc_cnt = 0;
    rdy_bad = 0;
  endtask

  task automatic send(input logic [15:0] m, input logic l);
    int g;
    g = 0;
    s_valid = 1'b1;
    s_mag = m;
    s_last = l;
    @(negedge clk);
    while (!s_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    last_wait = g;
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout s_ready=%b required 1", s_ready);
    end
    step;
    s_valid = 1'b0;
  endtask

  task automatic wait_done;
    int g;
    g = 0;
    while (fd_cnt == 0 && g < 1000) begin
      step;
      g++;
    end
    step;
  endtask

  function automatic int bad_cols(input int lo, input int n);
    int bad;
    bad = 0;
    for (int c = lo; c < lo + n; c++) begin
      wr_t e;
      e = {4'b1000 >> (c / 144), 11'(c % 144), 10'(bar_h[c / 12])};
      if (c >= wq.size()) bad++;
      else if (wq[c] !== e) bad++;
    end
    return bad;
  endfunction

  task test_reset;
    do_reset;
    @(negedge clk);
    checks++; if (wr_bank !== 4'b0) begin errors++; $display("FAIL reset_wr_bank got %b want 0000", wr_bank); end
    checks++; if (wr_addr !== 11'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 10'd0) begin errors++; $display("FAIL reset_wr_data got %0d want 0", wr_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    step;
  endtask

  task test_full_frame;
    clear_log;
    for (int k = 0; k < 48; k++) bar_h[k] = k;
    for (int k = 0; k < 48; k++) send(16'(k * 64), k == 47);
    wait_done;
    checks++; if (acc_cnt !== 48) begin errors++; $display("FAIL full_accepts got %0d want 48", acc_cnt); end
    checks++; if (wq.size() !== 576) begin errors++; $display("FAIL full_write_count got %0d want 576", wq.size()); end
    checks++; if (bad_cols(0, 576) !== 0) begin errors++; $display("FAIL full_columns bad %0d want 0", bad_cols(0, 576)); end
    checks++; if (bad_cols(144, 12) !== 0) begin errors++; $display("FAIL full_bar12 bad %0d want 0", bad_cols(144, 12)); end
    checks++; if (bad_cols(564, 12) !== 0) begin errors++; $display("FAIL full_bar47 bad %0d want 0", bad_cols(564, 12)); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", fd_cnt); end
    if (wq.size() == 576) begin
      checks++; if (wq[144] !== {4'b0100, 11'd0, 10'd12}) begin errors++; $display("FAIL full_bar12_first got %h want %h", wq[144], {4'b0100, 11'd0, 10'd12}); end
      checks++; if (wq[575] !== {4'b0001, 11'd143, 10'd47}) begin errors++; $display("FAIL full_bar47_last got %h want %h", wq[575], {4'b0001, 11'd143, 10'd47}); end
      checks++; if (fd_cyc !== wcyc[575] + 1) begin errors++; $display("FAIL full_done_timing got %0d want %0d", fd_cyc, wcyc[575] + 1); end
      checks++; if (wcyc[575] - acc_first !== 622) begin errors++; $display("FAIL full_frame_latency got %0d want 622", wcyc[575] - acc_first); end
    end
  endtask

  task test_clamp;
    logic [15:0] mags[4];
    mags = '{16'hFFFF, 16'h7FC0, 16'd6400, 16'd63};
    bar_h[0] = 479; bar_h[1] = 479; bar_h[2] = 100; bar_h[3] = 0;
    do_reset;
    clear_log;
    for (int k = 0; k < 4; k++) send(mags[k], 1'b0);
    repeat (14) step;
    checks++; if (wq.size() !== 48) begin errors++; $display("FAIL clamp_write_count got %0d want 48", wq.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bad_cols(k * 12, 12) !== 0) begin errors++; $display("FAIL clamp_%0d mag %h bad %0d want 0 (height %0d)", k, mags[k], bad_cols(k * 12, 12), bar_h[k]); end
    end
    do_reset;
  endtask

  task test_early_last;
    for (int k = 0; k < 48; k++) bar_h[k] = (k < 6) ? k : 0;
    do_reset;
    clear_log;
    for (int k = 0; k < 6; k++) send(16'(k * 64 + 7), k == 5);
    wait_done;
    checks++; if (wq.size() !== 576) begin errors++; $display("FAIL early_write_count got %0d want 576", wq.size()); end
    checks++; if (bad_cols(0, 576) !== 0) begin errors++; $display("FAIL early_columns bad %0d want 0", bad_cols(0, 576)); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL early_done_count got %0d want 1", fd_cnt); end
    if (wq.size() == 576) begin
      checks++; if (wq[72] !== {4'b1000, 11'd72, 10'd0}) begin errors++; $display("FAIL early_flush_first got %h want %h", wq[72], {4'b1000, 11'd72, 10'd0}); end
      checks++; if (fd_cyc !== wcyc[575] + 1) begin errors++; $display("FAIL early_done_timing got %0d want %0d", fd_cyc, wcyc[575] + 1); end
    end
    clear_log;
    bar_h[0] = 10;
    send(16'd640, 1'b0);
    repeat (14) step;
    checks++; if (wq.size() !== 12 || bad_cols(0, 12) !== 0) begin errors++; $display("FAIL early_next_bin count %0d bad %0d want 12/0", wq.size(), bad_cols(0, 12)); end
    do_reset;
  endtask

  task test_drain;
    int waits;
    for (int k = 0; k < 48; k++) bar_h[k] = k;
    do_reset;
    clear_log;
    for (int k = 0; k < 48; k++) send(16'(k * 64), 1'b0);
    repeat (13) step;
    waits = 0;
    send(16'd100, 1'b0);
    waits += last_wait;
    step;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1 || wr_bank !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL drain_idle ready/bank/busy got %b/%b/%b want 1/0000/1", s_ready, wr_bank, busy); end
    step;
    send(16'd200, 1'b0);
    waits += last_wait;
    send(16'd300, 1'b1);
    waits += last_wait;
    step;
    step;
    checks++; if (waits !== 0) begin errors++; $display("FAIL drain_ready_waits got %0d want 0", waits); end
    checks++; if (wq.size() !== 576) begin errors++; $display("FAIL drain_write_count got %0d want 576", wq.size()); end
    checks++; if (bad_cols(0, 576) !== 0) begin errors++; $display("FAIL drain_columns bad %0d want 0", bad_cols(0, 576)); end
    checks++; if (fd_cnt !== 1 || fd_cyc !== acc_last) begin errors++; $display("FAIL drain_done count %0d cyc %0d want 1 at %0d", fd_cnt, fd_cyc, acc_last); end
  endtask

  task test_back_to_back;
    int gap_bad;
    for (int k = 0; k < 6; k++) bar_h[k] = k;
    do_reset;
    clear_log;
    for (int k = 0; k < 6; k++) begin
      repeat ((k % 2) ? $urandom_range(1, 3) : 0) step;
      send(16'(k * 64 + 5), 1'b0);
    end
    repeat (14) step;
    gap_bad = 0;
    for (int i = 0; i < wq.size(); i++) if (wcyc[i] !== wcyc[i - i % 12] + i % 12) gap_bad++;
    checks++; if (acc_cnt !== 6) begin errors++; $display("FAIL bp_accepts got %0d want 6", acc_cnt); end
    checks++; if (wq.size() !== 72 || bad_cols(0, 72) !== 0) begin errors++; $display("FAIL bp_columns count %0d bad %0d want 72/0", wq.size(), bad_cols(0, 72)); end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL bp_ready_during_write got %0d want 0", rdy_bad); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL bp_contiguous_bars got %0d want 0", gap_bad); end
    do_reset;
  endtask

  task test_reset_mid;
    for (int k = 0; k < 48; k++) bar_h[k] = k;
    do_reset;
    clear_log;
    for (int k = 0; k < 21; k++) send(16'(k * 64), 1'b0);
    repeat (5) step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wr_bank !== 4'b0 || s_ready !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_state bank/ready/done got %b/%b/%b want 0000/1/0", wr_bank, s_ready, frame_done); end
    checks++; if (wq.size() !== 246 || bad_cols(0, 246) !== 0) begin errors++; $display("FAIL rstmid_pre_writes count %0d bad %0d want 246/0", wq.size(), bad_cols(0, 246)); end
    step;
    clear_log;
    bar_h[0] = 3;
    send(16'd192, 1'b0);
    repeat (14) step;
    checks++; if (wq.size() !== 12 || bad_cols(0, 12) !== 0) begin errors++; $display("FAIL rstmid_next_bin count %0d bad %0d want 12/0", wq.size(), bad_cols(0, 12)); end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_clamp;
    test_early_last;
    test_drain;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
